// File: rtl/regfile_port_ctrl.sv
// Register-file port controller: arbitrates rs1/rs2/rd/wdata/we between the
// core datapath and a debug/loader requester, and runs a zero-clear sweep of
// x1..x(NREGS-1) after reset or on request.
module regfile_port_ctrl #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter bit SWEEP_EN = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [AW-1:0]   core_rs1,
  input  logic [AW-1:0]   core_rs2,
  input  logic [AW-1:0]   core_rd,
  input  logic [XLEN-1:0] core_wdata,
  input  logic            core_we,
  output logic            core_stall,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_ack,
  output logic [XLEN-1:0] dbg_rdata,
  input  logic            clear_req,
  output logic            clear_busy,
  output logic [AW-1:0]   rf_rs1,
  output logic [AW-1:0]   rf_rs2,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            rf_we,
  input  logic [XLEN-1:0] rf_rdata1
);

  typedef enum logic [1:0] {
    ST_CLEAR    = 2'd0,
    ST_RUN      = 2'd1,
    ST_DBG_ACC  = 2'd2,
    ST_DBG_WAIT = 2'd3
  } state_e;

  localparam state_e        RESET_STATE = SWEEP_EN ? ST_CLEAR : ST_RUN;
  localparam logic [AW-1:0] ADDR_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0] IDX_FIRST   = AW'(1);
  localparam logic [AW-1:0] IDX_LAST    = AW'(NREGS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   sweep_idx_q, sweep_idx_d;
  logic            dbg_ack_q, dbg_ack_d;
  logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;

  // State, sweep index and debug response registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      sweep_idx_q <= IDX_FIRST;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Next-state logic: sweep progress, debug handshake, ack pulse and read capture.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    dbg_ack_d   = 1'b0;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      ST_CLEAR: begin
        // Debug requests are held off until the sweep finishes.
        if (sweep_idx_q == IDX_LAST) begin
          state_d     = ST_RUN;
          sweep_idx_d = IDX_FIRST;
        end else begin
          sweep_idx_d = sweep_idx_q + IDX_FIRST;
        end
      end
      ST_RUN: begin
        // Debug has priority; a simultaneous clear request is dropped.
        if (dbg_req) begin
          state_d = ST_DBG_ACC;
        end else if (clear_req) begin
          state_d     = ST_CLEAR;
          sweep_idx_d = IDX_FIRST;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DBG_ACC: begin
        state_d   = ST_DBG_WAIT;
        dbg_ack_d = 1'b1;
        if (!dbg_we) begin
          dbg_rdata_d = rf_rdata1;
        end else begin
          dbg_rdata_d = dbg_rdata_q;
        end
      end
      ST_DBG_WAIT: begin
        // Four-phase handshake: request must drop before the next access.
        if (!dbg_req) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DBG_WAIT;
        end
      end
      default: begin
        state_d     = RESET_STATE;
        sweep_idx_d = IDX_FIRST;
      end
    endcase
  end

  // Port mux: select who drives the register file and derive stall/busy from state.
  always_comb begin
    rf_rs1     = ADDR_ZERO;
    rf_rs2     = ADDR_ZERO;
    rf_rd      = ADDR_ZERO;
    rf_wdata   = {XLEN{1'b0}};
    rf_we      = 1'b0;
    core_stall = 1'b1;
    clear_busy = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        rf_rd      = sweep_idx_q;
        rf_we      = 1'b1;
        clear_busy = 1'b1;
      end
      ST_RUN: begin
        rf_rs1     = core_rs1;
        rf_rs2     = core_rs2;
        rf_rd      = core_rd;
        rf_wdata   = core_wdata;
        rf_we      = core_we;
        core_stall = 1'b0;
      end
      ST_DBG_ACC: begin
        // x0 is architecturally constant: a debug write to it is acked but dropped.
        rf_rs1   = dbg_addr;
        rf_rd    = dbg_addr;
        rf_wdata = dbg_wdata;
        rf_we    = dbg_we && (dbg_addr != ADDR_ZERO);
      end
      ST_DBG_WAIT: begin
        rf_we = 1'b0;
      end
      default: begin
        rf_we = 1'b0;
      end
    endcase
  end

  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
- Owns the register file's port set: rs1, rs2, rd, DataWr, RuWr.
- Arbitrates those ports between the single-cycle core datapath and a debug/loader requester that uses a req/ack handshake.
- After reset, or on request, sequences a zero-clear sweep of x1..x31.
- Sits between the core control/writeback logic and register_unit, and drives the core stall.

Parameters:
- XLEN, 32, data width
- NREGS, 32, register count; address width is log2(NREGS) = 5
- SWEEP_EN, 1, 1 = run the clear sweep after reset; 0 = go straight to RUN

Ports:
- CLK  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- core_rs1  in  5  core read address 1
- core_rs2  in  5  core read address 2
- core_rd  in  5  core write address
- core_wdata  in  XLEN  core writeback data
- core_we  in  1  core write enable
- core_stall  out  1  1 = core must hold PC and state
- dbg_req  in  1  debug access request, level
- dbg_we  in  1  1 = write, 0 = read; sampled with dbg_req
- dbg_addr  in  5  debug register index
- dbg_wdata  in  XLEN  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  XLEN  registered read result
- clear_req  in  1  start the clear sweep; honoured only in RUN
- clear_busy  out  1  sweep in progress
- rf_rs1  out  5  to register file
- rf_rs2  out  5  to register file
- rf_rd  out  5  to register file
- rf_wdata  out  XLEN  to register file
- rf_we  out  1  to register file
- rf_rdata1  in  XLEN  register file Rus1, combinational

Behaviour:
- Reset: synchronous, active-high; all state changes on the rising edge of CLK.
  - state = CLEAR if SWEEP_EN, else RUN; sweep_idx = 1.
  - dbg_ack = 0, dbg_rdata = 0.
  - core_stall and clear_busy are combinational from state: both 1 in CLEAR; with SWEEP_EN = 0, core_stall = 0 and clear_busy = 0.
- States: CLEAR, RUN, DBG_ACC, DBG_WAIT.
- CLEAR:
  - rf_we = 1, rf_rd = sweep_idx, rf_wdata = 0, rf_rs1 = rf_rs2 = 0.
  - sweep_idx increments each cycle; after writing index 31, go to RUN.
  - Duration is exactly 31 cycles; x0 is never written.
  - core_stall = 1, clear_busy = 1.
  - dbg_req is ignored (held off) until RUN.
- RUN:
  - Pass-through: rf_* = core_*; core_stall = 0.
  - At an edge with dbg_req = 1, go to DBG_ACC. The core's access in that same cycle completes normally.
  - At an edge with clear_req = 1 and dbg_req = 0, go to CLEAR with sweep_idx = 1.
  - clear_req and dbg_req together: debug wins; clear_req is dropped.
- DBG_ACC (exactly 1 cycle):
  - core_stall = 1; core_we is suppressed.
  - rf_rs1 = dbg_addr, rf_rd = dbg_addr, rf_wdata = dbg_wdata.
  - rf_we = dbg_we AND (dbg_addr != 0). A debug write to x0 is acked but never writes.
  - Read (dbg_we = 0): dbg_rdata <= rf_rdata1 at the end of the cycle.
  - dbg_ack = 1 in the following cycle (registered); go to DBG_WAIT.
  - dbg_rdata is valid when dbg_ack is high and holds until the next debug read or reset.
- DBG_WAIT:
  - core_stall = 1, rf_we = 0.
  - When dbg_req = 0, return to RUN.
  - If dbg_req stays high, stay here; a new access requires dbg_req to deassert for ≥1 cycle (four-phase handshake).
- dbg_ack:
  - High exactly one cycle per access: the first DBG_WAIT cycle. Never high in any other state.
- Latency:
  - dbg_req rising in RUN → dbg_ack 2 cycles later.
  - Core loses exactly 1 + (cycles dbg_req stays high after ack) cycles.
- Reset mid-operation: in any state, reset returns to the reset values and restarts the sweep if SWEEP_EN. A partial debug write already committed is not undone.
- Unused rf_rs2:
  - In DBG_ACC, rf_rs2 = 0.
  - In DBG_WAIT, rf_rs1 = rf_rs2 = 0 and rf_rd = 0.

Test Plan:
- Reset with SWEEP_EN = 1, register file preloaded with 0xFFFFFFFF → 31 cycles with rf_we = 1 and rf_rd = 1..31; then x1..x31 = 0, x0 untouched, core_stall falls in cycle 32.
- RUN, core_rd = 5, core_wdata = 0x12345678, core_we = 1 → rf mirrors core; x5 = 0x12345678 next cycle; core_stall = 0 throughout.
- dbg_req = 1, dbg_we = 1, dbg_addr = 7, dbg_wdata = 0xCAFEBABE, with core_we = 1 to rd = 9 in the same cycle → x9 written by the core; next cycle x7 = 0xCAFEBABE; dbg_ack pulses once 2 cycles after req; core_stall = 1 until req drops.
- Debug read of x7 → dbg_rdata = 0xCAFEBABE with dbg_ack. Hold dbg_req high 5 more cycles → no second ack; stall persists; RUN resumes the cycle after req drops.
- Debug write to x0 with data 0xDEADBEEF → rf_we stays 0, dbg_ack still pulses; a subsequent read returns 0.
- clear_req in RUN → 31-cycle sweep; assert reset at sweep cycle 10 → sweep restarts at idx 1; dbg_req raised during the sweep is acked only after the sweep completes.
